// File: rtl/wb_pipe_stage.sv
// Writeback pipeline stage: holds one retiring instruction, waits for load data,
// extends it, and drives the register-file write port plus hazard/forward info.
module wb_pipe_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_OFS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           m_valid,
  output logic                           m_ready,
  input  logic [31:0]                    m_pc,
  input  logic                           m_wen,
  input  logic [REG_AW-1:0]              m_dst,
  input  logic [1:0]                     m_src_sel,
  input  logic [2:0]                     m_load_type,
  input  logic [$clog2(DATA_W/8)-1:0]    m_addr_lo,
  input  logic [DATA_W-1:0]              m_alu,
  input  logic [DATA_W-1:0]              m_shift,
  input  logic                           dm_rvalid,
  input  logic [DATA_W-1:0]              dm_rdata,
  output logic                           rf_we,
  output logic [REG_AW-1:0]              rf_waddr,
  output logic [DATA_W-1:0]              rf_wdata,
  output logic [31:0]                    w_pc,
  output logic [1:0]                     w_tnew,
  output logic                           fwd_valid,
  output logic [CNT_W-1:0]               retire_cnt
);

  localparam int LW = $clog2(DATA_W/8);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q;
  logic                ent_wen_q;
  logic [REG_AW-1:0]   ent_dst_q;
  logic [2:0]          ent_ltype_q;
  logic [LW-1:0]       ent_lo_q;
  logic                out_wen_q;
  logic [REG_AW-1:0]   out_dst_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                commit;
  logic                ld_done;
  logic [31:0]         link_addr;
  logic [DATA_W-1:0]   exec_res;
  logic [DATA_W-1:0]   byte_sh;
  logic [DATA_W-1:0]   half_sh;
  logic [DATA_W-1:0]   load_res;

  assign m_ready = ~reset & ~flush & (state_q != S_WAIT);
  assign accept  = m_valid & m_ready;
  assign commit  = ~reset & ~flush & (state_q == S_FULL);
  assign ld_done = ~flush & dm_rvalid & (state_q == S_WAIT);

  assign link_addr = m_pc + 32'(LINK_OFS);

  always_comb begin
    exec_res = m_alu;
    case (m_src_sel)
      2'd2:    exec_res = m_shift;
      2'd3:    exec_res = DATA_W'(link_addr);
      default: exec_res = m_alu;
    endcase
  end

  // Lane selection by shifting the target lane down to bit 0.
  assign byte_sh = dm_rdata >> {ent_lo_q, 3'b000};
  assign half_sh = dm_rdata >> {ent_lo_q[LW-1:1], 4'b0000};

  always_comb begin
    load_res = dm_rdata;
    case (ent_ltype_q)
      3'd1:    load_res = {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]};
      3'd2:    load_res = {{(DATA_W-16){1'b0}}, half_sh[15:0]};
      3'd3:    load_res = {{(DATA_W-8){byte_sh[7]}}, byte_sh[7:0]};
      3'd4:    load_res = {{(DATA_W-8){1'b0}}, byte_sh[7:0]};
      default: load_res = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = (m_src_sel == 2'd1) ? S_WAIT : S_FULL;
        S_WAIT:  if (dm_rvalid) state_d = S_FULL;
        S_FULL:  begin
          if (accept) state_d = (m_src_sel == 2'd1) ? S_WAIT : S_FULL;
          else        state_d = S_EMPTY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Output registers only change when an entry enters FULL, so they hold the
  // last committed values while a new load sits in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      pc_q        <= '0;
      ent_wen_q   <= 1'b0;
      ent_dst_q   <= '0;
      ent_ltype_q <= '0;
      ent_lo_q    <= '0;
      out_wen_q   <= 1'b0;
      out_dst_q   <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + CNT_W'(commit);
      if (accept) begin
        pc_q        <= m_pc;
        ent_wen_q   <= m_wen;
        ent_dst_q   <= m_dst;
        ent_ltype_q <= m_load_type;
        ent_lo_q    <= m_addr_lo;
      end
      if (accept && m_src_sel != 2'd1) begin
        out_wen_q  <= m_wen;
        out_dst_q  <= m_dst;
        out_data_q <= exec_res;
      end else if (ld_done) begin
        out_wen_q  <= ent_wen_q;
        out_dst_q  <= ent_dst_q;
        out_data_q <= load_res;
      end
    end
  end

  assign rf_we      = commit & out_wen_q & (out_dst_q != '0);
  assign fwd_valid  = rf_we;
  assign rf_waddr   = reset ? '0 : out_dst_q;
  assign rf_wdata   = reset ? '0 : out_data_q;
  assign w_pc       = reset ? '0 : pc_q;
  assign w_tnew     = (~reset && state_q == S_WAIT) ? 2'd1 : 2'd0;
  // The count seen during FULL already includes the entry retiring that cycle.
  assign retire_cnt = reset ? '0 : cnt_q + CNT_W'(commit);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Testbench for wb_pipe_stage: table of entries plus hand sequences for flush,
// reset-in-WAIT, stray dm_rvalid and counter wrap; commits checked via scoreboard.
module tb_wb_pipe_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset, flush, m_valid, m_ready, m_wen, dm_rvalid;
  logic [31:0]       m_pc, w_pc;
  logic [REG_AW-1:0] m_dst, rf_waddr;
  logic [1:0]        m_src_sel, m_addr_lo, w_tnew;
  logic [2:0]        m_load_type;
  logic [DATA_W-1:0] m_alu, m_shift, dm_rdata, rf_wdata;
  logic              rf_we, fwd_valid;
  logic [CNT_W-1:0]  retire_cnt;

  wb_pipe_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LINK_OFS(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_pc(m_pc), .m_wen(m_wen), .m_dst(m_dst), .m_src_sel(m_src_sel),
    .m_load_type(m_load_type), .m_addr_lo(m_addr_lo), .m_alu(m_alu), .m_shift(m_shift),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .w_pc(w_pc), .w_tnew(w_tnew), .fwd_valid(fwd_valid),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic        wen;
    logic [4:0]  dst;
    logic [31:0] pc, alu, sh;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] rd;
    int unsigned dly;
    logic        we;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  vec_t        tbl[12];
  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [CNT_W-1:0] mdl_cnt = '0;
  logic [CNT_W-1:0] prev_cnt = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] src, input logic wen, input logic [4:0] dst,
                              input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sh,
                              input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] rd,
                              input int unsigned dly, input logic we, input logic [31:0] data);
    vec_t v;
    v.src = src; v.wen = wen; v.dst = dst; v.pc = pc; v.alu = alu; v.sh = sh;
    v.lt = lt; v.lo = lo; v.rd = rd; v.dly = dly; v.we = we; v.data = data;
    return v;
  endfunction

  // Scoreboard: every retire_cnt step is one commit and pops one expectation.
  always @(negedge clk) begin
    if (reset) begin
      mdl_cnt = '0; prev_cnt = '0; last_wdata = '0;
    end else begin
      chk("fwd_eq_we", fwd_valid, rf_we);
      if (retire_cnt != prev_cnt) begin
        mdl_cnt = mdl_cnt + 1'b1;
        chk("retire_cnt", retire_cnt, mdl_cnt);
        if (sbq.size() == 0) begin
          chk("spurious_commit", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rf_we", rf_we, e.we);
          chk("rf_waddr", rf_waddr, e.waddr);
          chk("rf_wdata", rf_wdata, e.wdata);
          chk("w_pc", w_pc, e.pc);
          chk("w_tnew_full", w_tnew, 0);
          last_wdata = e.wdata;
        end
        prev_cnt = retire_cnt;
      end else begin
        chk("no_commit_we", rf_we, 0);
      end
    end
  end

  task automatic idle_inputs();
    flush = 0; m_valid = 0; dm_rvalid = 0; m_pc = '0; m_wen = 0; m_dst = '0;
    m_src_sel = '0; m_load_type = '0; m_addr_lo = '0; m_alu = '0; m_shift = '0;
    dm_rdata = $urandom;
  endtask

  task automatic send(input vec_t v, input bit push);
    exp_t e;
    m_valid = 1; m_pc = v.pc; m_wen = v.wen; m_dst = v.dst; m_src_sel = v.src;
    m_load_type = v.lt; m_addr_lo = v.lo; m_alu = v.alu; m_shift = v.sh;
    @(negedge clk);
    chk("accept_ready", m_ready, 1);
    e.we = v.we; e.waddr = v.dst; e.wdata = v.data; e.pc = v.pc;
    if (push) sbq.push_back(e);
    @(posedge clk); #1;
    m_valid = 0; m_alu = $urandom; m_src_sel = 2'($urandom); m_load_type = 3'($urandom);
    if (v.src == 2'd1) begin
      for (int unsigned d = 1; d <= v.dly; d++) begin
        dm_rvalid = (d == v.dly);
        dm_rdata = (d == v.dly) ? v.rd : $urandom;
        @(negedge clk);
        chk("wait_ready", m_ready, 0);
        chk("wait_tnew", w_tnew, 1);
        chk("wait_hold_wdata", rf_wdata, last_wdata);
        @(posedge clk); #1;
        dm_rvalid = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; m_valid = 1; flush = 1; dm_rvalid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", m_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_fwd", fwd_valid, 0);
    chk("rst_tnew", w_tnew, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pc", w_pc, 0);
    chk("rst_cnt", retire_cnt, 0);
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_ready", m_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] saved;
    tbl[0]  = mk(2'd0, 1, 5'd8,  32'h0000_1000, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h1234_5678);
    tbl[1]  = mk(2'd3, 1, 5'd31, 32'h0000_3000, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0000_3008);
    tbl[2]  = mk(2'd2, 1, 5'd3,  32'h0000_1008, 32'h0, 32'hA5A5_0001, 3'd0, 2'd0, 32'h0, 0, 1, 32'hA5A5_0001);
    tbl[3]  = mk(2'd1, 1, 5'd5,  32'h0000_100C, 32'h0, 32'h0, 3'd3, 2'd2, 32'h0080_0000, 3, 1, 32'hFFFF_FF80);
    tbl[4]  = mk(2'd1, 1, 5'd6,  32'h0000_1010, 32'h0, 32'h0, 3'd2, 2'd3, 32'hBEEF_0000, 1, 1, 32'h0000_BEEF);
    tbl[5]  = mk(2'd1, 1, 5'd7,  32'h0000_1014, 32'h0, 32'h0, 3'd1, 2'd0, 32'h1234_8001, 2, 1, 32'hFFFF_8001);
    tbl[6]  = mk(2'd1, 1, 5'd9,  32'h0000_1018, 32'h0, 32'h0, 3'd4, 2'd1, 32'h0000_F000, 1, 1, 32'h0000_00F0);
    tbl[7]  = mk(2'd1, 1, 5'd10, 32'h0000_101C, 32'h0, 32'h0, 3'd0, 2'd1, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF);
    tbl[8]  = mk(2'd0, 1, 5'd0,  32'h0000_1020, 32'h5555_AAAA, 32'h0, 3'd0, 2'd0, 32'h0, 0, 0, 32'h5555_AAAA);
    tbl[9]  = mk(2'd0, 0, 5'd9,  32'h0000_1024, 32'h0BAD_F00D, 32'h0, 3'd0, 2'd0, 32'h0, 0, 0, 32'h0BAD_F00D);
    tbl[10] = mk(2'd3, 1, 5'd1,  32'hFFFF_FFFC, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0000_0004);
    tbl[11] = mk(2'd1, 1, 5'd2,  32'h0000_1028, 32'h0, 32'h0, 3'd3, 2'd3, 32'h7F00_0000, 1, 1, 32'h0000_007F);

    idle_inputs();
    do_reset();

    for (int i = 0; i < 12; i++) send(tbl[i], 1);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("table_drained", sbq.size(), 0);
    chk("empty_tnew", w_tnew, 0);
    @(posedge clk); #1;

    // Stray dm_rvalid in EMPTY must not commit anything.
    saved = retire_cnt;
    dm_rvalid = 1; dm_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 dm_rvalid = 0;
    @(negedge clk);
    chk("stray_rvalid_cnt", retire_cnt, saved);
    @(posedge clk); #1;

    // Flush in WAIT with dm_rvalid high: entry dropped, back to EMPTY.
    saved = retire_cnt;
    send(mk(2'd1, 1, 5'd12, 32'h0000_2000, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0), 0);
    flush = 1; dm_rvalid = 1; dm_rdata = 32'h1111_2222; m_valid = 1;
    @(negedge clk);
    chk("flush_wait_ready", m_ready, 0);
    chk("flush_wait_we", rf_we, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("flush_wait_empty", m_ready, 1);
    chk("flush_wait_tnew", w_tnew, 0);
    chk("flush_wait_cnt", retire_cnt, saved);
    @(posedge clk); #1;

    // Flush during FULL suppresses the write and the count.
    saved = retire_cnt;
    send(mk(2'd0, 1, 5'd13, 32'h0000_2004, 32'h7777_7777, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1, 32'h0), 0);
    flush = 1; m_valid = 1;
    @(negedge clk);
    chk("flush_full_we", rf_we, 0);
    chk("flush_full_fwd", fwd_valid, 0);
    chk("flush_full_cnt", retire_cnt, saved);
    chk("flush_full_ready", m_ready, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("flush_full_after_cnt", retire_cnt, saved);
    chk("flush_full_after_ready", m_ready, 1);
    @(posedge clk); #1;

    // Reset while a load waits: entry discarded.
    m_valid = 1; m_src_sel = 2'd1; m_wen = 1; m_dst = 5'd14; m_pc = 32'h0000_2008;
    @(posedge clk); #1;
    m_valid = 0; reset = 1; dm_rvalid = 1; dm_rdata = 32'h2222_3333;
    @(negedge clk);
    chk("rst_wait_we", rf_we, 0);
    chk("rst_wait_tnew", w_tnew, 0);
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    @(negedge clk);
    chk("rst_wait_ready", m_ready, 1);
    chk("rst_wait_cnt", retire_cnt, 0);
    @(posedge clk); #1;

    // 2^CNT_W+1 back-to-back ALU entries, one commit per cycle.
    for (int unsigned i = 0; i < (1 << CNT_W) + 1; i++) begin
      exp_t e;
      m_valid = 1; m_src_sel = 2'd0; m_wen = 1; m_dst = 5'((i % 31) + 1);
      m_alu = i * 3 + 1; m_pc = 32'h4000 + i * 4;
      e.we = 1; e.waddr = m_dst; e.wdata = m_alu; e.pc = m_pc;
      sbq.push_back(e);
      @(negedge clk);
      chk("burst_ready", m_ready, 1);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("burst_drained", sbq.size(), 0);
    chk("burst_wrap_cnt", retire_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width; it SHALL be a multiple of 32.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-003 The block SHALL have parameter LINK_OFS, default 8, meaning link offset added to PC for source 3.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning retire counter width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have these ports; LW = log2(DATA_W/8):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  drop held entry, block accept
- m_valid  in  1  MEM stage offers entry
- m_ready  out  1  stage can accept
- m_pc  in  32  instruction PC
- m_wen  in  1  entry writes register
- m_dst  in  REG_AW  destination register
- m_src_sel  in  2  result source: 0 ALU, 1 DM, 2 shift, 3 PC+LINK_OFS
- m_load_type  in  3  0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned
- m_addr_lo  in  LW  load byte offset
- m_alu, m_shift  in  DATA_W each  ALU and shifter results
- dm_rvalid  in  1  memory read data valid
- dm_rdata  in  DATA_W  memory read data
- rf_we  out  1  register write enable
- rf_waddr  out  REG_AW  register write address
- rf_wdata  out  DATA_W  register write data
- w_pc  out  32  PC of held entry
- w_tnew  out  2  cycles until result available: 0 or 1
- fwd_valid  out  1  forwardable result present
- retire_cnt  out  CNT_W  count of committed entries

Function
REQ-007 The block SHALL implement states EMPTY, WAIT, FULL.
REQ-008 m_ready SHALL be 1 in EMPTY and FULL, 0 in WAIT, and 0 whenever flush=1.
REQ-009 On accept (m_valid & m_ready & ~flush), all m_* fields SHALL be registered and the next state SHALL be WAIT if m_src_sel=1, otherwise FULL.
REQ-010 For sources 0, 2 and 3, the registered result SHALL be m_alu, m_shift, or m_pc+LINK_OFS zero-extended to DATA_W; the PC addition SHALL wrap mod 2^32.
REQ-011 In WAIT, when dm_rvalid=1 the block SHALL latch extended dm_rdata and go to FULL next cycle.
REQ-012 In WAIT, when dm_rvalid=0 the block SHALL remain in WAIT with no timeout.
REQ-013 Load extension SHALL work as follows:
- Word: the whole DATA_W word.
- Half: lane select m_addr_lo[LW-1:1], bit 0 ignored.
- Byte: lane select m_addr_lo.
- Signed types sign-extend; unsigned types zero-extend.
REQ-014 The FULL state SHALL last exactly one cycle per entry.
REQ-015 In FULL, rf_we SHALL be (wen & dst≠0), with rf_waddr=dst and rf_wdata the registered result.
REQ-016 In FULL, retire_cnt SHALL increment by 1 and wrap modulo 2^CNT_W, including entries with wen=0.
REQ-017 In EMPTY and WAIT, rf_we SHALL be 0; rf_waddr and rf_wdata SHALL hold their last values.
REQ-018 From FULL, the next state SHALL be WAIT or FULL on a same-cycle accept, otherwise EMPTY; back-to-back non-load entries SHALL commit on consecutive cycles.
REQ-019 fwd_valid SHALL equal rf_we; w_tnew SHALL be 1 in WAIT and 0 otherwise; w_pc SHALL equal the held PC.
REQ-020 flush=1 SHALL force rf_we=0 and fwd_valid=0 that cycle, with no retire_cnt increment.
REQ-021 flush=1 SHALL make the next state EMPTY and SHALL take priority over accept and dm_rvalid.
REQ-022 dm_rvalid outside WAIT SHALL be ignored.

Reset
REQ-023 While reset=1, the block SHALL:
- set state to EMPTY;
- drive rf_we, fwd_valid, w_tnew, rf_waddr, rf_wdata, w_pc and retire_cnt to 0;
- drive m_ready to 0;
- ignore m_valid, flush and dm_rvalid.
REQ-024 m_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 Reset during WAIT or FULL SHALL discard the entry with no register write.

Verification
REQ-026 ALU entry (m_alu=0x1234_5678, dst=8, wen=1) accepted at cycle 0 -> at cycle 1: rf_we=1, waddr=8, wdata=0x1234_5678, retire_cnt=1.
REQ-027 Link entry (src=3, m_pc=0x0000_3000, dst=31) -> rf_wdata=0x0000_3008 one cycle after accept.
REQ-028 Byte-signed load, addr_lo=2, dm_rdata=0x0080_0000, dm_rvalid 3 cycles after accept -> m_ready=0 and w_tnew=1 for 3 cycles, then rf_wdata=0xFFFF_FF80.
REQ-029 Half-unsigned load, addr_lo=3, dm_rdata=0xBEEF_0000 -> rf_wdata=0x0000_BEEF.
REQ-030 Entries with dst=0 or wen=0 -> rf_we=0 while retire_cnt still increments; flush in WAIT with dm_rvalid=1 -> no write, state EMPTY, count unchanged.
REQ-031 Run 2^CNT_W+1 back-to-back ALU entries -> one commit per cycle and retire_cnt=1 after wrap.
